// File: rtl/pulse_train_ctrl_if.sv
// Host <-> sequencer bundle: train request/abort, train shape, and the
// registered pulse line plus status returned to the host.
interface pulse_train_ctrl_if #(
   parameter int CNT_W = 8,
   parameter int REP_W = 8
);
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [REP_W-1:0] reps;
   logic             out;
   logic             busy;
   logic             done;

   // Host side: issues requests, observes the line and status.
   modport master (
      output start, stop, high_len, low_len, reps,
      input  out, busy, done
   );

   // Sequencer side.
   modport slave (
      input  start, stop, high_len, low_len, reps,
      output out, busy, done
   );
endinterface

// File: rtl/pulse_train_ctrl.sv
// Pulse-train sequencer: drives a single registered line with reps x
// (high phase, low phase), reports busy while running and a one-cycle
// done on normal completion. Train shape is captured at start so the
// host may change its inputs while a train is running.
module pulse_train_ctrl #(
   parameter int CNT_W = 8,
   parameter int REP_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pulse_train_ctrl_if.slave        bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_reg,    state_next;
   logic [CNT_W-1:0] phase_cnt_reg, phase_cnt_next;
   logic [REP_W-1:0] rep_cnt_reg,  rep_cnt_next;
   logic [CNT_W-1:0] high_len_reg, high_len_next;
   logic [CNT_W-1:0] low_len_reg,  low_len_next;
   logic             out_reg,      out_next;
   logic             busy_reg,     busy_next;
   logic             done_reg,     done_next;

   // Helpers: high phase length is clamped to at least one cycle, and the
   // repetition count is only ever decremented when it is non-zero.
   logic [CNT_W-1:0] in_high_load;
   logic [CNT_W-1:0] sh_high_load;
   logic [REP_W-1:0] rep_dec;

   assign in_high_load = (bus.high_len == '0) ? '0 : bus.high_len - 1'b1;
   assign sh_high_load = (high_len_reg == '0) ? '0 : high_len_reg - 1'b1;
   assign rep_dec      = (rep_cnt_reg == '0) ? '0 : rep_cnt_reg - 1'b1;

   // State, counter, shadow and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         phase_cnt_reg <= '0;
         rep_cnt_reg   <= '0;
         high_len_reg  <= '0;
         low_len_reg   <= '0;
         out_reg       <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         phase_cnt_reg <= phase_cnt_next;
         rep_cnt_reg   <= rep_cnt_next;
         high_len_reg  <= high_len_next;
         low_len_reg   <= low_len_next;
         out_reg       <= out_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   // Next-state and next-output decode; outputs follow the next state so
   // they are registered and aligned with the state they describe.
   always_comb begin
      state_next     = state_reg;
      phase_cnt_next = phase_cnt_reg;
      rep_cnt_next   = rep_cnt_reg;
      high_len_next  = high_len_reg;
      low_len_next   = low_len_reg;

      case (state_reg)
         S_IDLE: begin
            if (bus.start && !bus.stop) begin
               high_len_next = bus.high_len;
               low_len_next  = bus.low_len;
               if (bus.reps == '0) begin
                  state_next = S_DONE;
               end else begin
                  state_next     = S_HIGH;
                  phase_cnt_next = in_high_load;
                  rep_cnt_next   = bus.reps;
               end
            end
         end
         S_HIGH: begin
            if (bus.stop) begin
               state_next = S_IDLE;
            end else if (phase_cnt_reg != '0) begin
               phase_cnt_next = phase_cnt_reg - 1'b1;
            end else if (low_len_reg != '0) begin
               state_next     = S_LOW;
               phase_cnt_next = low_len_reg - 1'b1;
            end else begin
               // No low phase: the repetition ends with the high phase.
               rep_cnt_next = rep_dec;
               if (rep_dec == '0) begin
                  state_next = S_DONE;
               end else begin
                  phase_cnt_next = sh_high_load;
               end
            end
         end
         S_LOW: begin
            if (bus.stop) begin
               state_next = S_IDLE;
            end else if (phase_cnt_reg != '0) begin
               phase_cnt_next = phase_cnt_reg - 1'b1;
            end else begin
               rep_cnt_next = rep_dec;
               if (rep_dec == '0) begin
                  state_next = S_DONE;
               end else begin
                  state_next     = S_HIGH;
                  phase_cnt_next = sh_high_load;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      out_next  = (state_next == S_HIGH);
      busy_next = (state_next == S_HIGH) || (state_next == S_LOW);
      done_next = (state_next == S_DONE);
   end

   assign bus.out  = out_reg;
   assign bus.busy = busy_reg;
   assign bus.done = done_reg;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Bench for pulse_train_ctrl: stimulus pushes the expected per-cycle
// waveform and expected done cycles; a negedge monitor pops and compares.
module tb_pulse_train_ctrl;
   localparam int CW = 8;
   localparam int RW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pulse_train_ctrl_if #(.CNT_W(CW), .REP_W(RW)) bus ();

   pulse_train_ctrl #(.CNT_W(CW), .REP_W(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int   cyc;
      logic o;
      logic b;
      logic d;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   end_req = 1'b0;
   bit   end_ack = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare the waveform each cycle an expectation exists, and
   // match every done pulse against the expected done cycles.
   always @(negedge clk) begin : mon
      exp_t e;
      int   dc;
      if (!end_req) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL stale cycle %0d: got no sample, want out=%b busy=%b done=%b", e.cyc, e.o, e.b, e.d);
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.out !== e.o || bus.busy !== e.b || bus.done !== e.d) begin
               n_err++;
               $display("FAIL wave cycle %0d: got out=%b busy=%b done=%b, want out=%b busy=%b done=%b",
                        cyc, bus.out, bus.busy, bus.done, e.o, e.b, e.d);
            end
         end
         if (bus.done === 1'b1) begin
            n_cmp++;
            if (done_q.size() == 0) begin
               n_err++;
               $display("FAIL done cycle %0d: got unexpected done, want none", cyc);
            end else begin
               dc = done_q.pop_front();
               if (dc != cyc) begin
                  n_err++;
                  $display("FAIL done cycle: got %0d, want %0d", cyc, dc);
               end else begin
                  $display("[%0d] done pulse", cyc);
               end
            end
         end
      end else if (!end_ack) begin
         end_ack = 1'b1;
         n_cmp++;
         if (exp_q.size() != 0 || done_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d wave / %0d done expectations unconsumed, want 0 / 0",
                     exp_q.size(), done_q.size());
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_win(input int a, input int b, input logic o, input logic bz, input logic d);
      for (int i = a; i <= b; i++) begin
         exp_t e;
         e.cyc = i;
         e.o   = o;
         e.b   = bz;
         e.d   = d;
         exp_q.push_back(e);
      end
   endtask

   // Expected waveform of a train started (start sampled) in cycle t.
   task automatic push_train(input int t, input int h, input int l, input int r, output int done_c);
      int c;
      int hh;
      c  = t + 1;
      hh = (h == 0) ? 1 : h;
      for (int k = 0; k < r; k++) begin
         expect_win(c, c + hh - 1, 1'b1, 1'b1, 1'b0);
         c += hh;
         if (l > 0) begin
            expect_win(c, c + l - 1, 1'b0, 1'b1, 1'b0);
            c += l;
         end
      end
      expect_win(c, c, 1'b0, 1'b0, 1'b1);
      done_q.push_back(c);
      done_c = c;
   endtask

   task automatic set_shape(input int h, input int l, input int r);
      bus.high_len = CW'(h);
      bus.low_len  = CW'(l);
      bus.reps     = RW'(r);
   endtask

   // Full undisturbed train followed by two idle cycles.
   task automatic do_train(input int h, input int l, input int r);
      int t;
      int dc;
      t = cyc;
      $display("[%0d] train h=%0d l=%0d r=%0d", t, h, l, r);
      set_shape(h, l, r);
      bus.start = 1'b1;
      push_train(t, h, l, r, dc);
      expect_win(dc + 1, dc + 2, 1'b0, 1'b0, 1'b0);
      next_cycle();
      bus.start = 1'b0;
      while (cyc < dc + 3) next_cycle();
   endtask

   initial begin : stim
      int t;
      int dc;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      set_shape(0, 0, 0);

      // Reset held three cycles, then idle.
      next_cycle();
      t = cyc;
      $display("[%0d] reset then idle", t);
      expect_win(t, t + 24, 1'b0, 1'b0, 1'b0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      repeat (22) next_cycle();

      // Basic train, hand-written waveform.
      t = cyc;
      $display("[%0d] basic train h=3 l=2 r=2", t);
      set_shape(3, 2, 2);
      bus.start = 1'b1;
      expect_win(t + 1,  t + 3,  1'b1, 1'b1, 1'b0);
      expect_win(t + 4,  t + 5,  1'b0, 1'b1, 1'b0);
      expect_win(t + 6,  t + 8,  1'b1, 1'b1, 1'b0);
      expect_win(t + 9,  t + 10, 1'b0, 1'b1, 1'b0);
      expect_win(t + 11, t + 11, 1'b0, 1'b0, 1'b1);
      expect_win(t + 12, t + 14, 1'b0, 1'b0, 1'b0);
      done_q.push_back(t + 11);
      next_cycle();
      bus.start = 1'b0;
      repeat (13) next_cycle();

      // Ignored starts (busy, DONE cycle, with stop) and mid-train shape change.
      t = cyc;
      $display("[%0d] ignored starts and latching", t);
      set_shape(3, 2, 2);
      bus.start = 1'b1;
      push_train(t, 3, 2, 2, dc);
      expect_win(t + 12, t + 16, 1'b0, 1'b0, 1'b0);
      next_cycle();
      bus.start = 1'b0;
      set_shape(7, 0, 9);
      repeat (3) next_cycle();
      bus.start = 1'b1;
      next_cycle();
      bus.start = 1'b0;
      repeat (6) next_cycle();
      bus.start = 1'b1;
      next_cycle();
      bus.start = 1'b0;
      next_cycle();
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      next_cycle();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      repeat (3) next_cycle();

      // Zero-length cases.
      t = cyc;
      $display("[%0d] empty train r=0", t);
      set_shape(4, 4, 0);
      bus.start = 1'b1;
      expect_win(t + 1, t + 1, 1'b0, 1'b0, 1'b1);
      expect_win(t + 2, t + 4, 1'b0, 1'b0, 1'b0);
      done_q.push_back(t + 1);
      next_cycle();
      bus.start = 1'b0;
      repeat (4) next_cycle();

      t = cyc;
      $display("[%0d] zero lengths h=0 l=0 r=3", t);
      set_shape(0, 0, 3);
      bus.start = 1'b1;
      expect_win(t + 1, t + 3, 1'b1, 1'b1, 1'b0);
      expect_win(t + 4, t + 4, 1'b0, 1'b0, 1'b1);
      expect_win(t + 5, t + 6, 1'b0, 1'b0, 1'b0);
      done_q.push_back(t + 4);
      next_cycle();
      bus.start = 1'b0;
      repeat (6) next_cycle();

      // Abort inside LOW, then a fresh train at T+10.
      t = cyc;
      $display("[%0d] abort h=5 l=5 r=4", t);
      set_shape(5, 5, 4);
      bus.start = 1'b1;
      expect_win(t + 1, t + 5,  1'b1, 1'b1, 1'b0);
      expect_win(t + 6, t + 7,  1'b0, 1'b1, 1'b0);
      expect_win(t + 8, t + 10, 1'b0, 1'b0, 1'b0);
      push_train(t + 10, 2, 1, 2, dc);
      expect_win(dc + 1, dc + 2, 1'b0, 1'b0, 1'b0);
      next_cycle();
      bus.start = 1'b0;
      repeat (6) next_cycle();
      bus.stop = 1'b1;
      next_cycle();
      bus.stop = 1'b0;
      repeat (2) next_cycle();
      $display("[%0d] fresh train h=2 l=1 r=2", cyc);
      set_shape(2, 1, 2);
      bus.start = 1'b1;
      next_cycle();
      bus.start = 1'b0;
      while (cyc < dc + 3) next_cycle();

      // Maximum lengths.
      do_train(255, 0, 2);
      do_train(1, 0, 255);
      do_train(2, 3, 1);

      // Asynchronous reset during HIGH, dropped between clock edges.
      t = cyc;
      $display("[%0d] async reset mid-train", t);
      set_shape(6, 1, 3);
      bus.start = 1'b1;
      expect_win(t + 1, t + 2,  1'b1, 1'b1, 1'b0);
      expect_win(t + 3, t + 10, 1'b0, 1'b0, 1'b0);
      next_cycle();
      bus.start = 1'b0;
      next_cycle();
      next_cycle();
      #1;
      rst_n = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      repeat (6) next_cycle();

      end_req = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
